// File: rtl/clk_div_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick divider.
// Derives half-period counts for the 50 MHz board clock.
package clk_div_pkg;

    localparam int unsigned SYS_HALF_HZ      = 25_000_000;
    localparam int          CNT_W_DEF        = 26;
    localparam int unsigned DEFAULT_HALF_DEF = 24_999_999;

    // Output level of a channel; the low phase precedes the high phase.
    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Half-period count H giving an output frequency of f Hz at 50 MHz.
    function automatic int unsigned half_for_hz(input int unsigned f);
        return SYS_HALF_HZ / f - 1;
    endfunction

    // Width of a channel index, never less than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of clk_div_multi: sync, enables, config write, outputs.
// cfg_low exists only when CLKDIV_DUTY_EN is defined.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic              sync;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0]  cfg_low;
`endif
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output sync, ch_en, cfg_we, cfg_ch, cfg_half,
`ifdef CLKDIV_DUTY_EN
        output cfg_low,
`endif
        input  clk_out, tick
    );

    modport slave (
        input  sync, ch_en, cfg_we, cfg_ch, cfg_half,
`ifdef CLKDIV_DUTY_EN
        input  cfg_low,
`endif
        output clk_out, tick
    );

endinterface

// File: rtl/clk_div_multi_ch.sv
// One divider channel: down-counter, pending period update applied at period end, registered outputs.
// CLKDIV_DUTY_EN adds an independent low-phase count.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk_50mhz,
    input  logic             reset_n,
    input  logic             sync,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_half,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0] wr_low,
`endif
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] half_p;
    logic             pend;
    phase_e           phase;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] low_p;
`endif

    logic [CNT_W-1:0] eff_half;
    logic [CNT_W-1:0] eff_low;
    logic             terminal;
    logic             apply;

    // Values that become active on an applying edge; reloads on that edge already use them.
    always_comb begin
        eff_half = pend ? half_p : half_q;
`ifdef CLKDIV_DUTY_EN
        eff_low  = pend ? low_p : low_q;
`else
        eff_low  = eff_half;
`endif
        terminal = (cnt == '0);
        apply    = sync || !en || (terminal && phase == PH_HIGH);
    end

    // NOTE: every register is reset, including the period registers, so a
    // channel restarts at the default rate without needing a config write.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= RST_HALF;
            half_q <= RST_HALF;
            half_p <= RST_HALF;
            pend   <= 1'b0;
            phase  <= PH_LOW;
            tick   <= 1'b0;
`ifdef CLKDIV_DUTY_EN
            low_q  <= RST_HALF;
            low_p  <= RST_HALF;
`endif
        end else begin
            if (apply && pend) begin
                half_q <= half_p;
`ifdef CLKDIV_DUTY_EN
                low_q  <= low_p;
`endif
                pend   <= 1'b0;
            end
            // NOTE: non-blocking assignments, last one wins: a write coinciding
            // with an apply keeps its new value pending for the next period end.
            if (we) begin
                half_p <= wr_half;
`ifdef CLKDIV_DUTY_EN
                low_p  <= wr_low;
`endif
                pend   <= 1'b1;
            end

            if (sync || !en) begin
                cnt   <= eff_half;
                phase <= PH_LOW;
                tick  <= 1'b0;
            end else if (terminal) begin
                if (phase == PH_HIGH) begin
                    phase <= PH_LOW;
                    cnt   <= eff_low;
                    tick  <= 1'b0;
                end else begin
                    phase <= PH_HIGH;
                    cnt   <= half_q;
                    tick  <= 1'b1;
                end
            end else begin
                cnt  <= cnt - 1'b1;
                tick <= 1'b0;
            end
        end
    end

    assign clk_out = phase;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH programmable clock/tick dividers off clk_50mhz; use tick as a clock enable downstream.
// Define CLKDIV_DUTY_EN for a separately programmable low phase.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic            clk_50mhz,
    input  logic            reset_n,
    clk_div_multi_if.slave  bus
);
    logic [NUM_CH-1:0] clk_out_v;
    logic [NUM_CH-1:0] tick_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no instance and are dropped.
        logic wr_en;
        assign wr_en = bus.cfg_we && (int'(bus.cfg_ch) == i);

        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_50mhz (clk_50mhz),
            .reset_n   (reset_n),
            .sync      (bus.sync),
            .en        (bus.ch_en[i]),
            .we        (wr_en),
            .wr_half   (bus.cfg_half),
`ifdef CLKDIV_DUTY_EN
            .wr_low    (bus.cfg_low),
`endif
            .clk_out   (clk_out_v[i]),
            .tick      (tick_v[i])
        );
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEFAULT_HALF = 9 (period 20); five channels so index 5 is out of range.
// The CLKDIV_DUTY_EN build adds a high/low duty check.
module tb_clk_div_multi;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 26;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DEF_H  = 9;

    logic clk_50mhz;
    logic reset_n;
    int   tests;
    int   failed;
    int   n;
    int   tick_sum;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF_H)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_50mhz);
        #1;
    endtask

    // Edges until clk_out[ch] reaches level; -1 if the budget runs out.
    task automatic cycles_to(input int ch, input logic level, input int max_n, output int cnt);
        cnt = 0;
        while (cnt < max_n) begin
            step(1);
            cnt++;
            if (bus.clk_out[ch] === level) return;
        end
        cnt = -1;
    endtask

    task automatic cfg_write(input int ch, input int half, input int low);
        bus.cfg_ch   = ch[CH_W-1:0];
        bus.cfg_half = half[CNT_W-1:0];
`ifdef CLKDIV_DUTY_EN
        bus.cfg_low  = low[CNT_W-1:0];
`else
        if (low < 0) $display("cfg_write: negative low ignored");
`endif
        bus.cfg_we   = 1'b1;
        step(1);
        bus.cfg_we   = 1'b0;
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset_n      = 1'b0;
        bus.sync     = 1'b0;
        bus.ch_en    = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_half = '0;
`ifdef CLKDIV_DUTY_EN
        bus.cfg_low  = '0;
`endif

        // Reset state
        repeat (2) @(posedge clk_50mhz);
        #5;
        check("reset_clk_out", int'(bus.clk_out), 0);
        check("reset_tick", int'(bus.tick), 0);
        check("reset_half_q", int'(dut.g_ch[0].u_ch.half_q), DEF_H);

        // Default rate on ch0: first rise after H+1 edges, period 2*(H+1)
        bus.ch_en = 5'b00001;
        reset_n   = 1'b1;
        cycles_to(0, 1'b1, 100, n);
        check("def_first_rise", n, 10);
        check("def_first_tick", int'(bus.tick[0]), 1);
        step(1);
        check("def_tick_one_cycle", int'(bus.tick[0]), 0);
        cycles_to(0, 1'b0, 100, n);
        check("def_high_len", n, 9);
        cycles_to(0, 1'b1, 100, n);
        check("def_low_len", n, 10);
        check("def_second_tick", int'(bus.tick[0]), 1);
        bus.ch_en = '0;
        step(2);

        // Run-time reprogram of ch1: H=4, then H=1 written mid-high
        cfg_write(1, 4, 4);
        step(1);
        bus.ch_en = 5'b00010;
        cycles_to(1, 1'b1, 100, n);
        check("rep_enable_latency", n, 5);
        step(2);
        cfg_write(1, 1, 1);
        cycles_to(1, 1'b0, 100, n);
        check("rep_old_high_finishes", n, 2);
        cycles_to(1, 1'b1, 100, n);
        check("rep_new_low", n, 2);
        check("rep_new_tick", int'(bus.tick[1]), 1);
        cycles_to(1, 1'b0, 100, n);
        check("rep_new_high", n, 2);
        cycles_to(1, 1'b1, 100, n);
        check("rep_new_low2", n, 2);

        // Disable ch1 while high
        bus.ch_en = 5'b00000;
        step(1);
        check("dis_clk_out", int'(bus.clk_out[1]), 0);
        check("dis_tick", int'(bus.tick[1]), 0);
        check("dis_cnt", int'(dut.g_ch[1].u_ch.cnt), 1);

        // Sync alignment of ch0 and ch2, both H=3, enabled at different times
        cfg_write(0, 3, 3);
        cfg_write(2, 3, 3);
        step(1);
        bus.ch_en = 5'b00001;
        step(3);
        bus.ch_en = 5'b00101;
        step(5);
        bus.sync = 1'b1;
        step(1);
        bus.sync = 1'b0;
        check("sync_ch0_low", int'(bus.clk_out[0]), 0);
        check("sync_ch2_low", int'(bus.clk_out[2]), 0);
        step(3);
        check("sync_hold_ch0", int'(bus.clk_out[0]), 0);
        check("sync_hold_ch2", int'(bus.clk_out[2]), 0);
        step(1);
        check("sync_rise_ch0", int'(bus.clk_out[0]), 1);
        check("sync_rise_ch2", int'(bus.clk_out[2]), 1);
        check("sync_tick_ch0", int'(bus.tick[0]), 1);
        check("sync_tick_ch2", int'(bus.tick[2]), 1);
        step(8);
        check("sync_next_tick_ch0", int'(bus.tick[0]), 1);
        check("sync_next_tick_ch2", int'(bus.tick[2]), 1);
        bus.ch_en = '0;
        step(1);

        // ch3 with H=0: toggles every edge, tick every second edge
        cfg_write(3, 0, 0);
        step(1);
        bus.ch_en = 5'b01000;
        step(1);
        check("h0_rise1", int'(bus.clk_out[3]), 1);
        check("h0_tick1", int'(bus.tick[3]), 1);
        step(1);
        check("h0_fall1", int'(bus.clk_out[3]), 0);
        check("h0_tick_off", int'(bus.tick[3]), 0);
        step(1);
        check("h0_rise2", int'(bus.clk_out[3]), 1);
        check("h0_tick2", int'(bus.tick[3]), 1);

        // Out-of-range write changes nothing
        cfg_write(5, 7, 7);
        check("oor_fall", int'(bus.clk_out[3]), 0);
        step(1);
        check("oor_rise", int'(bus.clk_out[3]), 1);
        check("oor_ch3_pend", int'(dut.g_ch[3].u_ch.pend), 0);
        check("oor_ch4_half_p", int'(dut.g_ch[4].u_ch.half_p), DEF_H);
        check("oor_ch0_half_p", int'(dut.g_ch[0].u_ch.half_p), 3);

        // Write on the falling terminal count: old value runs one more period
        cfg_write(3, 2, 2);
        check("tc_fall", int'(bus.clk_out[3]), 0);
        step(1);
        check("tc_old_low", int'(bus.clk_out[3]), 1);
        step(1);
        check("tc_old_high", int'(bus.clk_out[3]), 0);
        cycles_to(3, 1'b1, 100, n);
        check("tc_new_low", n, 3);
        cycles_to(3, 1'b0, 100, n);
        check("tc_new_high", n, 3);
        cycles_to(3, 1'b1, 100, n);
        check("tc_pre_reset_high", int'(bus.clk_out[3]), 1);

        // Asynchronous reset mid-count
        #5;
        reset_n = 1'b0;
        #1;
        check("arst_clk_out", int'(bus.clk_out), 0);
        check("arst_tick", int'(bus.tick), 0);
        check("arst_half_q_ch3", int'(dut.g_ch[3].u_ch.half_q), DEF_H);
        check("arst_half_q_ch1", int'(dut.g_ch[1].u_ch.half_q), DEF_H);
        bus.ch_en = '0;
        @(posedge clk_50mhz);
        #5;
        reset_n = 1'b1;
        step(1);

`ifdef CLKDIV_DUTY_EN
        // Independent low phase: H=2, L=6
        cfg_write(2, 2, 6);
        step(1);
        bus.ch_en = 5'b00100;
        cycles_to(2, 1'b1, 100, n);
        check("duty_first_rise", n, 3);
        cycles_to(2, 1'b0, 100, n);
        check("duty_high", n, 3);
        cycles_to(2, 1'b1, 100, n);
        check("duty_low", n, 7);
        tick_sum = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            tick_sum += int'(bus.tick[2]);
        end
        check("duty_ticks_per_10", tick_sum, 1);
`else
        tick_sum = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
